// File: rtl/change_dispenser_if.sv
// -----------------------------------------------------------------------------
// change_dispenser_if
//   Request/response bundle between the vending FSM (master) and the coin
//   dispenser (slave).
//   master drives : start, amount, restock, restock_sel, restock_cnt
//   slave drives  : ready, eject_25/10/5, done, short, remaining,
//                   inv_25/10/5
// -----------------------------------------------------------------------------
interface change_dispenser_if #(
   parameter int INV_WIDTH = 8
);
   // payout request
   logic                 start;
   logic [7:0]           amount;
   // inventory restock
   logic                 restock;
   logic [1:0]           restock_sel;
   logic [INV_WIDTH-1:0] restock_cnt;
   // status / ejector strobes
   logic                 ready;
   logic                 eject_25;
   logic                 eject_10;
   logic                 eject_5;
   logic                 done;
   logic                 short;
   logic [7:0]           remaining;
   logic [INV_WIDTH-1:0] inv_25;
   logic [INV_WIDTH-1:0] inv_10;
   logic [INV_WIDTH-1:0] inv_5;

   modport master (
      output start, amount, restock, restock_sel, restock_cnt,
      input  ready, eject_25, eject_10, eject_5, done, short, remaining,
             inv_25, inv_10, inv_5
   );

   modport slave (
      input  start, amount, restock, restock_sel, restock_cnt,
      output ready, eject_25, eject_10, eject_5, done, short, remaining,
             inv_25, inv_10, inv_5
   );
endinterface

// File: rtl/change_dispenser.sv
// -----------------------------------------------------------------------------
// change_dispenser
//   Pays a change amount one coin at a time (quarter > dime > nickel, greedy,
//   no backtracking) limited by a per-denomination inventory, and reports the
//   unpaid remainder. Owns the inventory counters including restocking.
//   Ports:
//     clk    - single clock, rising edge
//     reset  - synchronous, active-high; returns to IDLE, reloads inventory
//     bus    - change_dispenser_if.slave (request, restock, strobes, status)
// -----------------------------------------------------------------------------

// One inventory counter. A SELECT decrement and a restock on the same edge
// both apply; the combined result saturates at all-ones.
module change_dispenser_coin_inv #(
   parameter int INV_WIDTH = 8,
   parameter int INIT      = 20
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 dec,
   input  logic                 add,
   input  logic [INV_WIDTH-1:0] add_cnt,
   output logic [INV_WIDTH-1:0] inv
);
   localparam logic [INV_WIDTH:0] MAX = {1'b0, {INV_WIDTH{1'b1}}};

   // one extra bit so inv - dec + add_cnt cannot wrap; dec is only ever
   // raised when inv is non-zero, so the subtraction never underflows
   logic [INV_WIDTH:0] sum;

   always_comb begin
      sum = {1'b0, inv} - {{INV_WIDTH{1'b0}}, dec};
      if (add)
         sum = sum + {1'b0, add_cnt};
   end

   always_ff @(posedge clk) begin
      if (reset)
         inv <= INV_WIDTH'(INIT);
      else if (sum > MAX)
         inv <= '1;
      else
         inv <= sum[INV_WIDTH-1:0];
   end
endmodule

module change_dispenser #(
   parameter int PULSE_CYCLES = 4,
   parameter int GAP_CYCLES   = 4,
   parameter int INV_WIDTH    = 8,
   parameter int INIT_25      = 20,
   parameter int INIT_10      = 20,
   parameter int INIT_5       = 20
) (
   input  logic               clk,
   input  logic               reset,
   change_dispenser_if.slave  bus
);
   localparam int NUM_COINS = 3;

   // coin index 0 = quarter, 1 = dime, 2 = nickel (same order as restock_sel)
   localparam logic [NUM_COINS-1:0][7:0] COIN_VAL = {8'd5, 8'd10, 8'd25};
   localparam int INIT_V [NUM_COINS] = '{INIT_25, INIT_10, INIT_5};

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_SELECT = 3'd1;
   localparam logic [2:0] S_PULSE  = 3'd2;
   localparam logic [2:0] S_GAP    = 3'd3;
   localparam logic [2:0] S_DONE   = 3'd4;

   localparam int CNT_MAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] P_LAST = CNT_W'(PULSE_CYCLES - 1);
   localparam logic [CNT_W-1:0] G_LAST = CNT_W'(GAP_CYCLES - 1);

   logic [2:0]                          state;
   logic [CNT_W-1:0]                    cnt;
   logic [7:0]                          remaining;
   logic [NUM_COINS-1:0]                sel_coin;   // one-hot coin being ejected
   logic [NUM_COINS-1:0][INV_WIDTH-1:0] inv;
   logic [NUM_COINS-1:0]                pick;       // one-hot greedy choice
   logic [7:0]                          pick_val;
   logic [NUM_COINS-1:0]                dec_vec;
   logic [NUM_COINS-1:0]                add_vec;

   // Greedy choice from the pre-edge remaining and inventory. Scanning from
   // the smallest coin upward lets the largest eligible coin win.
   always_comb begin
      pick     = '0;
      pick_val = '0;
      for (int i = NUM_COINS - 1; i >= 0; i--) begin
         if (remaining >= COIN_VAL[i] && inv[i] != '0) begin
            pick     = '0;
            pick[i]  = 1'b1;
            pick_val = COIN_VAL[i];
         end
      end
   end

   assign dec_vec = (state == S_SELECT) ? pick : '0;

   for (genvar g = 0; g < NUM_COINS; g++) begin : g_inv
      assign add_vec[g] = bus.restock && (bus.restock_sel == 2'(g));

      change_dispenser_coin_inv #(
         .INV_WIDTH (INV_WIDTH),
         .INIT      (INIT_V[g])
      ) u_inv (
         .clk     (clk),
         .reset   (reset),
         .dec     (dec_vec[g]),
         .add     (add_vec[g]),
         .add_cnt (bus.restock_cnt),
         .inv     (inv[g])
      );
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         cnt       <= '0;
         remaining <= '0;
         sel_coin  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  remaining <= bus.amount;
                  state     <= S_SELECT;
               end
            end
            S_SELECT: begin
               cnt <= '0;
               if (|pick) begin
                  sel_coin  <= pick;
                  remaining <= remaining - pick_val;
                  state     <= S_PULSE;
               end else begin
                  state <= S_DONE;
               end
            end
            S_PULSE: begin
               if (cnt == P_LAST) begin
                  cnt   <= '0;
                  state <= S_GAP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_GAP: begin
               if (cnt == G_LAST) begin
                  cnt   <= '0;
                  state <= S_SELECT;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   // Strobes decode from state + the latched one-hot coin, so they are high
   // exactly for the PULSE cycles and can never overlap.
   assign bus.eject_25  = (state == S_PULSE) && sel_coin[0];
   assign bus.eject_10  = (state == S_PULSE) && sel_coin[1];
   assign bus.eject_5   = (state == S_PULSE) && sel_coin[2];
   assign bus.ready     = (state == S_IDLE);
   assign bus.done      = (state == S_DONE);
   assign bus.short     = (state == S_DONE) && (remaining != 8'd0);
   assign bus.remaining = remaining;
   assign bus.inv_25    = inv[0];
   assign bus.inv_10    = inv[1];
   assign bus.inv_5     = inv[2];
endmodule
